// File: rtl/mcpu_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - FSM state encodings (also visible on the debug `state` output)
//   - opcode / func field constants for the supported instruction set
//   - ALUOp, PCSrc and RegDst encodings
//   - instruction class enum and the decoded-instruction struct
package mcpu_defs;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_WB_AL  = 4'd3,
    S_EXE_BR = 4'd4,
    S_EXE_LS = 4'd5,
    S_MEM    = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type func codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_OR  = 3'b011,
    ALU_AND = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef enum logic [3:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_JAL,
    CLS_JR,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic         is_bne;    // branch sense: 1 = bne, 0 = beq
    alu_op_e      alu_op;
    logic         alu_src_a; // 1 = shift amount
    logic         alu_src_b; // 1 = extended immediate
    logic         ext_sel;   // 1 = sign-extend
  } dec_t;

endpackage

// File: rtl/multicycle_control_unit_op_decoder.sv
// op_decoder: combinational instruction decoder.
// Ports:
//   op_i   [5:0]  opcode field
//   func_i [5:0]  R-type function field
//   dec_o  dec_t  instruction class plus ALUOp / ALUSrcA / ALUSrcB / ExtSel
// Anything outside the supported set decodes as CLS_ILLEGAL, which the FSM
// retires as a PC+4 nop.
module op_decoder
  import mcpu_defs::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o           = '0;
    dec_o.cls       = CLS_ILLEGAL;
    dec_o.alu_op    = ALU_ADD;
    dec_o.ext_sel   = 1'b1;

    // Halt is checked first so a HALT_OP override always wins.
    if (op_i == HALT_OP) begin
      dec_o.cls = CLS_HALT;
    end else begin
      case (op_i)
        OP_RTYPE: begin
          dec_o.cls = CLS_ALU_R;
          case (func_i)
            FN_ADD: dec_o.alu_op = ALU_ADD;
            FN_SUB: dec_o.alu_op = ALU_SUB;
            FN_AND: dec_o.alu_op = ALU_AND;
            FN_OR:  dec_o.alu_op = ALU_OR;
            FN_SLT: dec_o.alu_op = ALU_SLT;
            FN_SLL: begin
              dec_o.alu_op    = ALU_SLL;
              dec_o.alu_src_a = 1'b1;
            end
            FN_JR:   dec_o.cls = CLS_JR;
            default: dec_o.cls = CLS_ILLEGAL;
          endcase
        end
        OP_ADDI: begin
          dec_o.cls       = CLS_ALU_I;
          dec_o.alu_src_b = 1'b1;
        end
        OP_ORI: begin
          dec_o.cls       = CLS_ALU_I;
          dec_o.alu_op    = ALU_OR;
          dec_o.alu_src_b = 1'b1;
          dec_o.ext_sel   = 1'b0;
        end
        OP_LW: begin
          dec_o.cls       = CLS_LOAD;
          dec_o.alu_src_b = 1'b1;
        end
        OP_SW: begin
          dec_o.cls       = CLS_STORE;
          dec_o.alu_src_b = 1'b1;
        end
        OP_BEQ: begin
          dec_o.cls    = CLS_BRANCH;
          dec_o.alu_op = ALU_SUB;
        end
        OP_BNE: begin
          dec_o.cls    = CLS_BRANCH;
          dec_o.is_bne = 1'b1;
          dec_o.alu_op = ALU_SUB;
        end
        OP_J:    dec_o.cls = CLS_JUMP;
        OP_JAL:  dec_o.cls = CLS_JAL;
        default: dec_o.cls = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: control FSM for the multi-cycle MIPS datapath.
// Ports:
//   CLK, Reset (sync, active-high)
//   op, func   instruction fields from the field splitter
//   zero       ALU zero flag, used in EXE_BR
//   state      current FSM state (debug)
//   PCWre, IRWre, RegWre, mRD, mWR           datapath enables
//   ALUSrcA, ALUSrcB, ExtSel, DBDataSrc,
//   WrRegDSrc, RegDst, PCSrc, ALUOp          datapath mux selects
// All outputs are combinational from the state register and latched op/func.
// Selects not meaningful in a state are driven to 0.
module multicycle_control_unit
  import mcpu_defs::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  output logic [3:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp
);

  state_e     state_q, state_d;
  logic [5:0] op_q, func_q;
  logic [5:0] dec_op, dec_func;
  dec_t       dec;
  logic       br_taken;

  // During ID the instruction register has just been loaded, so the live
  // fields are decoded; afterwards only the copies captured at the end of ID
  // are used, so later IR/bus activity cannot disturb an instruction.
  assign dec_op   = (state_q == S_ID) ? op   : op_q;
  assign dec_func = (state_q == S_ID) ? func : func_q;

  op_decoder #(.HALT_OP(HALT_OP)) u_dec (
    .op_i   (dec_op),
    .func_i (dec_func),
    .dec_o  (dec)
  );

  assign br_taken = dec.is_bne ? ~zero : zero;
  assign state    = state_q;

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // op/func capture at the end of ID
  always_ff @(posedge CLK) begin
    if (Reset) begin
      op_q   <= '0;
      func_q <= '0;
    end else if (state_q == S_ID) begin
      op_q   <= op;
      func_q <= func;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (dec.cls)
          CLS_ALU_R, CLS_ALU_I: state_d = S_EXE_AL;
          CLS_BRANCH:           state_d = S_EXE_BR;
          CLS_LOAD, CLS_STORE:  state_d = S_EXE_LS;
          CLS_HALT:             state_d = S_HALT;
          default:              state_d = S_IF; // j, jal, jr, illegal
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (dec.cls == CLS_LOAD) ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  // Output logic
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    RegDst    = REGDST_RA;
    PCSrc     = PCSRC_PC4;
    ALUOp     = ALU_ADD;

    // Once the instruction is known, the ALU-side selects follow the decode
    // for the rest of the instruction.
    if (state_q != S_IF && state_q != S_HALT) begin
      ALUSrcA = dec.alu_src_a;
      ALUSrcB = dec.alu_src_b;
      ExtSel  = dec.ext_sel;
      ALUOp   = dec.alu_op;
    end

    case (state_q)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        case (dec.cls)
          CLS_JUMP: begin
            PCWre = 1'b1;
            PCSrc = PCSRC_JUMP;
          end
          CLS_JAL: begin
            PCWre     = 1'b1;
            PCSrc     = PCSRC_JUMP;
            RegWre    = 1'b1;
            RegDst    = REGDST_RA;
            WrRegDSrc = 1'b1;
          end
          CLS_JR: begin
            PCWre = 1'b1;
            PCSrc = PCSRC_RS;
          end
          CLS_ILLEGAL: PCWre = 1'b1;
          default: ;
        endcase
      end
      S_WB_AL: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
        RegDst = (dec.cls == CLS_ALU_R) ? REGDST_RD : REGDST_RT;
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = br_taken ? PCSRC_BRANCH : PCSRC_PC4;
      end
      S_MEM: begin
        if (dec.cls == CLS_LOAD) begin
          mRD = 1'b1;
        end else begin
          mWR   = 1'b1;
          PCWre = 1'b1;
        end
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = REGDST_RT;
        DBDataSrc = 1'b1;
      end
      default: ;
    endcase

    // Reset masks every write so a mid-instruction reset cannot commit.
    if (Reset) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Control FSM that sequences the multi-cycle MIPS datapath. It takes the opcode/function fields produced by the instruction field splitter and the ALU flags, steps each instruction through IF/ID/EXE/MEM/WB, and drives every datapath enable and mux select. It sits beside the instruction register and replaces the single-cycle combinational control.

## Interface
Parameters:
- `HALT_OP`, default 6'b111111: opcode that parks the FSM in HALT.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `op`  in  6  instruction[31:26] from the field splitter.
- `func`  in  6  instruction[5:0] from the field splitter.
- `zero`  in  1  ALU result == 0.
- `state`  out  4  current FSM state, for debug and display.
- `PCWre`  out  1  PC write enable.
- `IRWre`  out  1  instruction register write enable.
- `RegWre`  out  1  register file write enable.
- `mRD`  out  1  data memory read.
- `mWR`  out  1  data memory write.
- `ALUSrcA`  out  1  0 = rs, 1 = sa (shifts).
- `ALUSrcB`  out  1  0 = rt, 1 = extended immediate.
- `ExtSel`  out  1  0 = zero-extend, 1 = sign-extend.
- `DBDataSrc`  out  1  0 = ALU result, 1 = memory data.
- `WrRegDSrc`  out  1  0 = DB bus, 1 = PC+4 (jal).
- `RegDst`  out  2  00 = $31, 01 = rt, 10 = rd.
- `PCSrc`  out  2  00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- `ALUOp`  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt.

## Operation
- Supported set:
  - R-type (op 000000) with func add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000.
  - addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, halt = `HALT_OP`.
- `op`/`func` are latched into internal registers on the ID cycle. EXE/MEM/WB decode uses only the latched copies.
- States: IF=0, ID=1, EXE_AL=2, WB_AL=3, EXE_BR=4, EXE_LS=5, MEM=6, WB_LD=7, HALT=8.
- Transitions:
  - IF→ID.
  - ID→IF for j, jal, jr and for any unsupported op/func (executed as a nop that advances PC+4).
  - ID→HALT for halt.
  - ID→EXE_BR for beq/bne.
  - ID→EXE_LS for lw/sw.
  - ID→EXE_AL for arithmetic ops.
  - EXE_AL→WB_AL→IF.
  - EXE_BR→IF.
  - EXE_LS→MEM.
  - MEM→WB_LD for lw; MEM→IF for sw.
  - WB_LD→IF.
  - HALT→HALT until `Reset`.
- Enables:
  - IRWre=1 only in IF.
  - PCWre=1 only in the final cycle of each instruction: ID for j/jal/jr/nop, EXE_BR, WB_AL, MEM for sw, WB_LD.
  - RegWre=1 in WB_AL, in WB_LD, and in ID for jal (RegDst=00, WrRegDSrc=1).
  - mRD=1 in MEM for lw; mWR=1 in MEM for sw.
- Branches: PCSrc=01 when (beq & zero) | (bne & !zero), else 00. ALUOp=sub in EXE_BR.
- Extension: ExtSel=0 for ori, 1 otherwise.
- Width rule: unused selects are driven to 0, never X.

## Timing
- Outputs are combinational from the registered state plus the latched op/func. There is no output register.
- `zero` is sampled combinationally in EXE_BR.
- Cycles per instruction: j/jal/jr/nop 2, beq/bne 3, R-type/addi/ori 4, sw 4, lw 5.
- Reset:
  - A rising edge with `Reset`=1 forces state=IF and clears the latched op/func.
  - While `Reset`=1, PCWre, IRWre, RegWre, mRD and mWR are forced to 0 regardless of state.
  - Reset asserted mid-instruction (e.g. in MEM for sw) suppresses that cycle's write.
- After reset deasserts, the first cycle is IF with IRWre=1.
- HALT: all enables 0, state stays 8 indefinitely.

## Structure
- Package `mcpu_defs`: state encodings, opcode and func constants, ALUOp/PCSrc/RegDst encodings.
- Sub-module `op_decoder` (combinational): latched op/func → instruction class (alu_r, alu_i, load, store, branch, jump, jal, jr, halt, illegal) plus ALUOp/ALUSrc/ExtSel.
- The top-level FSM uses that class for transitions and enables.

## Test plan
- Reset for 2 cycles, then release → state IF, IRWre=1, PCWre=0, then ID on the next cycle.
- add (op 0, func 100000) → states 0,1,2,3,0; RegWre=1 and PCWre=1 only in WB_AL; RegDst=10, ALUOp=000.
- lw then sw:
  - lw → 5 cycles; mRD=1 in MEM, RegWre=1 with DBDataSrc=1 in WB_LD.
  - sw → mWR=1 in MEM, then IF; RegWre never 1.
- beq with zero=1 → PCSrc=01, PCWre=1 in EXE_BR; bne with zero=1 → PCSrc=00.
- jal → 2 cycles; in ID: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=1. jr → PCSrc=10 in ID.
- Boundary cases:
  - halt → state 8 held for 20 cycles with all enables 0; Reset returns state to IF.
  - Reset asserted in MEM of sw → mWR=0 that cycle.
  - Illegal op 6'b010000 → 2-cycle nop with PCSrc=00.
